systolic_array_nxn: RTL and testbench

- Parametrised N×N output-stationary systolic matrix multiplier; successor to the fixed 2×2 array.
- Computes C = A×B for N×N operands streamed one k-slice per beat (column k of A, row k of B) over a valid/ready handshake.
- Applies the diagonal input skew internally, so callers no longer hand-stagger operands.
- Controller FSM drains the array, pulses done and holds results; supports signed/unsigned mode and sticky per-PE overflow flags.

---
 rtl/systolic_array_nxn.sv | 203 ++++++++++++++++++++
 tb/tb_systolic_array_nxn.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_nxn.sv
// Parametrised NxN output-stationary systolic matrix multiplier (C = A x B).
// Operands arrive one k-slice per beat; the diagonal skew is applied internally.
module systolic_array_nxn #(
    parameter int N      = 2,
    parameter int DW     = 32,
    parameter int ACC_W  = 64,
    parameter int SIGNED = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*DW-1:0]        a_col,
    input  logic [N*DW-1:0]        b_row,
    output logic                   busy,
    output logic                   done,
    output logic [N*N*ACC_W-1:0]   result,
    output logic [N*N-1:0]         carry
);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_t;

    localparam int CW = $clog2(2 * N) + 1;
    localparam logic [CW-1:0] LAST_BEAT  = CW'(N - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(2 * N - 1);

    state_t         state, state_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic           clear;
    logic           accept;
    logic [N*DW-1:0] a_skewed;
    logic [N*DW-1:0] b_skewed;

    assign clear  = start && ((state == IDLE) || (state == DONE));
    assign accept = (state == FEED) && in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // One counter serves both the beat count in FEED and the drain count.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FEED;
                    cnt_next   = '0;
                end
            end
            FEED: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (cnt == LAST_BEAT) begin
                        state_next = DRAIN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (cnt == LAST_DRAIN) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = FEED;
                    cnt_next   = '0;
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Lane i passes through i+1 registers; non-accepted cycles inject zeros.
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DW-1:0] a_sr [0:i];
        logic [DW-1:0] b_sr [0:i];

        always_ff @(posedge clk) begin
            if (rst || clear) begin
                for (int d = 0; d <= i; d++) begin
                    a_sr[d] <= '0;
                    b_sr[d] <= '0;
                end
            end else begin
                a_sr[0] <= accept ? a_col[i*DW +: DW] : '0;
                b_sr[0] <= accept ? b_row[i*DW +: DW] : '0;
                for (int d = 1; d <= i; d++) begin
                    a_sr[d] <= a_sr[d-1];
                    b_sr[d] <= b_sr[d-1];
                end
            end
        end

        assign a_skewed[i*DW +: DW] = a_sr[i];
        assign b_skewed[i*DW +: DW] = b_sr[i];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DW-1:0]    a_in;
            logic [DW-1:0]    b_in;
            logic [2*DW-1:0]  a_ext;
            logic [2*DW-1:0]  b_ext;
            logic [2*DW-1:0]  prod;
            logic [ACC_W-1:0] prod_ext;
            logic [ACC_W-1:0] acc;
            logic [ACC_W:0]   sum;
            logic             ovf;
            logic             flag;

            if (j == 0) begin : g_a_src
                assign a_in = a_skewed[i*DW +: DW];
            end else begin : g_a_src
                assign a_in = g_row[i].g_col[j-1].g_a_fwd.a_reg;
            end

            if (i == 0) begin : g_b_src
                assign b_in = b_skewed[j*DW +: DW];
            end else begin : g_b_src
                assign b_in = g_row[i-1].g_col[j].g_b_fwd.b_reg;
            end

            // Edge PEs have no neighbour to feed, so they keep no forwarding register.
            if (j < N - 1) begin : g_a_fwd
                logic [DW-1:0] a_reg;
                always_ff @(posedge clk) begin
                    if (rst || clear) a_reg <= '0;
                    else              a_reg <= a_in;
                end
            end

            if (i < N - 1) begin : g_b_fwd
                logic [DW-1:0] b_reg;
                always_ff @(posedge clk) begin
                    if (rst || clear) b_reg <= '0;
                    else              b_reg <= b_in;
                end
            end

            // Low 2*DW bits of the product of extended operands give the signed product too.
            always_comb begin
                if (SIGNED != 0) begin
                    a_ext    = {{DW{a_in[DW-1]}}, a_in};
                    b_ext    = {{DW{b_in[DW-1]}}, b_in};
                    prod     = a_ext * b_ext;
                    prod_ext = ACC_W'($signed(prod));
                end else begin
                    a_ext    = {{DW{1'b0}}, a_in};
                    b_ext    = {{DW{1'b0}}, b_in};
                    prod     = a_ext * b_ext;
                    prod_ext = ACC_W'(prod);
                end
                sum = {1'b0, acc} + {1'b0, prod_ext};
                if (SIGNED != 0)
                    ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                          (sum[ACC_W-1] != acc[ACC_W-1]);
                else
                    ovf = sum[ACC_W];
            end

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    acc  <= '0;
                    flag <= 1'b0;
                end else begin
                    acc <= sum[ACC_W-1:0];
                    if (ovf) flag <= 1'b1;
                end
            end

            assign result[(i*N+j)*ACC_W +: ACC_W] = acc;
            assign carry[i*N+j]                   = flag;
        end
    end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Directed self-checking bench for systolic_array_nxn: 2x2 unsigned, 4x4 signed
// and 1x1 instances share one clock and reset.
module tb_systolic_array_nxn;

    logic clk;
    logic rst;

    logic          start2, in_valid2, in_ready2, busy2, done2;
    logic [63:0]   a_col2, b_row2;
    logic [255:0]  result2;
    logic [3:0]    carry2;

    logic          start4, in_valid4, in_ready4, busy4, done4;
    logic [127:0]  a_col4, b_row4;
    logic [1023:0] result4;
    logic [15:0]   carry4;

    logic          start1, in_valid1, in_ready1, busy1, done1;
    logic [7:0]    a_col1, b_row1;
    logic [15:0]   result1;
    logic [0:0]    carry1;

    int checks;
    int errors;

    localparam logic [63:0]  A0 = {32'd3, 32'd1};
    localparam logic [63:0]  B0 = {32'd2, 32'd1};
    localparam logic [63:0]  A1 = {32'd4, 32'd2};
    localparam logic [63:0]  B1 = {32'd4, 32'd3};
    localparam logic [255:0] C_REF = {64'd22, 64'd15, 64'd10, 64'd7};
    localparam logic [255:0] C_ID  = {64'd1, 64'd0, 64'd0, 64'd1};

    systolic_array_nxn #(.N(2), .DW(32), .ACC_W(64), .SIGNED(0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
        .a_col(a_col2), .b_row(b_row2), .busy(busy2), .done(done2),
        .result(result2), .carry(carry2)
    );

    systolic_array_nxn #(.N(4), .DW(32), .ACC_W(64), .SIGNED(1)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid4), .in_ready(in_ready4),
        .a_col(a_col4), .b_row(b_row4), .busy(busy4), .done(done4),
        .result(result4), .carry(carry4)
    );

    systolic_array_nxn #(.N(1), .DW(8), .ACC_W(16), .SIGNED(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
        .a_col(a_col1), .b_row(b_row1), .busy(busy1), .done(done1),
        .result(result1), .carry(carry1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start2();
        start2 = 1'b1;
        step();
        start2 = 1'b0;
    endtask

    // Two beats with 'gap' bubble cycles between them; garbage is driven during bubbles.
    task automatic feed2(input logic [63:0] a0, input logic [63:0] b0,
                         input logic [63:0] a1, input logic [63:0] b1, input int gap);
        in_valid2 = 1'b1; a_col2 = a0; b_row2 = b0;
        step();
        in_valid2 = 1'b0; a_col2 = 64'hDEAD_BEEF_1234_5678; b_row2 = 64'hCAFE_F00D_8765_4321;
        repeat (gap) step();
        in_valid2 = 1'b1; a_col2 = a1; b_row2 = b1;
        step();
        in_valid2 = 1'b0; a_col2 = '0; b_row2 = '0;
    endtask

    task automatic wait_done2(output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (done2) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({in_ready2, busy2, done2} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl2: got %b, want 000", {in_ready2, busy2, done2});
        end
        checks++;
        if (result2 !== '0 || carry2 !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data2: result %h carry %b, want 0", result2, carry2);
        end
        checks++;
        if ({in_ready4, busy4, done4} !== 3'b000 || result4 !== '0 || carry4 !== '0) begin
            errors++;
            $display("[TB] FAIL reset_4x4: ctrl %b carry %h, want all 0",
                     {in_ready4, busy4, done4}, carry4);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int lat;
        pulse_start2();
        checks++;
        if ({in_ready2, busy2} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL basic_feed_flags: got %b, want 11", {in_ready2, busy2});
        end
        feed2(A0, B0, A1, B1, 0);
        wait_done2(lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d, want 4", lat);
        end
        for (int e = 0; e < 4; e++) begin
            checks++;
            if (result2[e*64 +: 64] !== C_REF[e*64 +: 64]) begin
                errors++;
                $display("[TB] FAIL basic_C%0d: got %0d, want %0d", e,
                         result2[e*64 +: 64], C_REF[e*64 +: 64]);
            end
        end
        checks++;
        if (carry2 !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL basic_carry: got %b, want 0000", carry2);
        end
        step();
        checks++;
        if ({done2, busy2} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL basic_done_pulse: done/busy %b, want 00", {done2, busy2});
        end
        step();
        checks++;
        if (result2 !== C_REF) begin
            errors++;
            $display("[TB] FAIL basic_hold: got %h, want %h", result2, C_REF);
        end
    endtask

    task automatic test_bubble();
        int lat;
        pulse_start2();
        feed2(A0, B0, A1, B1, 1);
        checks++;
        if ({in_ready2, busy2} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL bubble_drain_ready: got %b, want 01", {in_ready2, busy2});
        end
        // Valid beats offered during DRAIN must be ignored.
        in_valid2 = 1'b1; a_col2 = 64'h0000_0009_0000_0009; b_row2 = 64'h0000_0009_0000_0009;
        wait_done2(lat);
        in_valid2 = 1'b0; a_col2 = '0; b_row2 = '0;
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("[TB] FAIL bubble_latency: got %0d, want 4", lat);
        end
        checks++;
        if (result2 !== C_REF || carry2 !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL bubble_result: got %h carry %b, want %h carry 0000",
                     result2, carry2, C_REF);
        end
    endtask

    task automatic test_signed();
        int lat;
        logic [63:0] expv;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid4 = 1'b1;
            a_col4 = '0;
            a_col4[k*32 +: 32] = 32'hFFFF_FFFF;
            for (int j = 0; j < 4; j++) b_row4[j*32 +: 32] = 32'(4*k + j + 1);
            step();
        end
        in_valid4 = 1'b0; a_col4 = '0; b_row4 = '0;
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (done4) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("[TB] FAIL signed_latency: got %0d, want 8", lat);
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                expv = 64'(-(4*i + j + 1));
                checks++;
                if (result4[(i*4+j)*64 +: 64] !== expv) begin
                    errors++;
                    $display("[TB] FAIL signed_C%0d%0d: got %h, want %h", i, j,
                             result4[(i*4+j)*64 +: 64], expv);
                end
            end
        end
        checks++;
        if (carry4 !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL signed_carry: got %h, want 0000", carry4);
        end
    endtask

    task automatic test_overflow();
        int lat;
        pulse_start2();
        feed2('1, '1, '1, '1, 0);
        wait_done2(lat);
        for (int e = 0; e < 4; e++) begin
            checks++;
            if (result2[e*64 +: 64] !== 64'hFFFF_FFFC_0000_0002) begin
                errors++;
                $display("[TB] FAIL overflow_C%0d: got %h, want fffffffc00000002", e,
                         result2[e*64 +: 64]);
            end
        end
        checks++;
        if (carry2 !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL overflow_carry: got %b, want 1111", carry2);
        end
    endtask

    task automatic test_reset_in_drain();
        int lat;
        int pulses;
        pulse_start2();
        feed2(A0, B0, A1, B1, 0);
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({in_ready2, busy2, done2} !== 3'b000 || result2 !== '0 || carry2 !== '0) begin
            errors++;
            $display("[TB] FAIL abort_state: ctrl %b result %h carry %b, want all 0",
                     {in_ready2, busy2, done2}, result2, carry2);
        end
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (done2) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got %0d pulses, want 0", pulses);
        end
        pulse_start2();
        feed2(A0, B0, A1, B1, 0);
        wait_done2(lat);
        checks++;
        if (lat !== 4 || result2 !== C_REF) begin
            errors++;
            $display("[TB] FAIL abort_rerun: lat %0d result %h, want 4 %h", lat, result2, C_REF);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        pulse_start2();
        feed2(A0, B0, A1, B1, 0);
        wait_done2(lat);
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        checks++;
        if (result2 !== '0 || in_ready2 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_clear: result %h ready %b, want 0 1", result2, in_ready2);
        end
        feed2({32'd0, 32'd1}, {32'd0, 32'd1}, {32'd1, 32'd0}, {32'd1, 32'd0}, 0);
        wait_done2(lat);
        checks++;
        if (lat !== 4 || result2 !== C_ID) begin
            errors++;
            $display("[TB] FAIL b2b_identity: lat %0d result %h, want 4 %h", lat, result2, C_ID);
        end
    endtask

    task automatic test_start_held();
        int lat;
        pulse_start2();
        start2 = 1'b1;
        feed2(A0, B0, A1, B1, 1);
        start2 = 1'b0;
        wait_done2(lat);
        checks++;
        if (lat !== 4 || result2 !== C_REF) begin
            errors++;
            $display("[TB] FAIL start_held: lat %0d result %h, want 4 %h", lat, result2, C_REF);
        end
    endtask

    task automatic test_single_mac();
        int lat;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        in_valid1 = 1'b1; a_col1 = 8'd200; b_row1 = 8'd200;
        step();
        in_valid1 = 1'b0; a_col1 = '0; b_row1 = '0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (done1) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (lat !== 2 || result1 !== 16'd40000 || carry1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_mac: lat %0d result %0d carry %b, want 2 40000 0",
                     lat, result1, carry1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start2 = 1'b0; in_valid2 = 1'b0; a_col2 = '0; b_row2 = '0;
        start4 = 1'b0; in_valid4 = 1'b0; a_col4 = '0; b_row4 = '0;
        start1 = 1'b0; in_valid1 = 1'b0; a_col1 = '0; b_row1 = '0;

        test_reset();
        test_basic();
        test_bubble();
        test_signed();
        test_overflow();
        test_reset_in_drain();
        test_back_to_back();
        test_start_held();
        test_single_mac();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
